src_operand_regfile: RTL

- Parametrised successor of the fixed 8x8 source-operand memory in first_cpu.
- Dual synchronous read ports (src1/src2) and one write port (ALU writeback), in one block.
- Hardware clear sequencer fills every entry with zero after reset or on request.
- Sits between the decode stage (read addresses) and the ALU (operands/writeback).

---
 rtl/src_operand_regfile_if.sv | 38 +++
 rtl/src_operand_regfile.sv | 137 +++++++++++++
 2 files changed

// File: rtl/src_operand_regfile_if.sv
// Decode/ALU side bundle of src_operand_regfile: two read ports, one writeback
// port, clear request and status flags.
interface src_operand_regfile_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  // No back-pressure anywhere: rd_en_x is taken every cycle it is high, and
  // rd_valid_x qualifies rd_data_x/par_err_x exactly one cycle later, only if
  // the file was in RUN when the request was sampled.
  logic              init_req;
  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic              rd_valid_a;
  logic              par_err_a;
  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid_b;
  logic              par_err_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_drop;
  logic              busy;

  modport master (
    output init_req, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, wr_en, wr_addr, wr_data,
    input  rd_data_a, rd_valid_a, par_err_a, rd_data_b, rd_valid_b, par_err_b,
           wr_drop, busy
  );

  modport slave (
    input  init_req, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, wr_en, wr_addr, wr_data,
    output rd_data_a, rd_valid_a, par_err_a, rd_data_b, rd_valid_b, par_err_b,
           wr_drop, busy
  );
endinterface

// File: rtl/src_operand_regfile.sv
// Source-operand register file: 2 registered read ports, 1 write port, hardware
// clear sequencer. Define SRC_REGFILE_PARITY_EN to store and check even parity.
module src_operand_regfile #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  src_operand_regfile_if.slave bus,
  output logic                dbg_state_o
);

`ifdef SRC_REGFILE_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [MEM_W-1:0]  mem_q [DEPTH];

  logic              run;
  logic              wr_in_rng;
  logic              wr_commit;
  logic              wr_drop_d, wr_drop_q;
  logic [1:0]        rd_en;
  logic [1:0]        rd_in_rng;
  logic [1:0]        rd_valid_d, rd_valid_q;
  logic [1:0]        par_err_d, par_err_q;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [MEM_W-1:0]  rd_word [2];
  logic [DATA_W-1:0] rd_data_d [2];
  logic [DATA_W-1:0] rd_data_q [2];

  assign run        = (state_q == S_RUN);
  assign rd_en      = {bus.rd_en_b, bus.rd_en_a};
  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;
  assign wr_in_rng  = int'(bus.wr_addr) < DEPTH;
  // A clear request wins over a same-cycle write so the clear is never undone.
  assign wr_commit  = bus.wr_en && run && wr_in_rng && !bus.init_req;
  assign wr_drop_d  = bus.wr_en && !wr_commit;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (bus.init_req) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_in_rng[p]  = int'(rd_addr[p]) < DEPTH;
      rd_word[p]    = mem_q[rd_addr[p]];
      rd_valid_d[p] = rd_en[p] && run;
      rd_data_d[p]  = rd_data_q[p];
      par_err_d[p]  = 1'b0;
      if (rd_valid_d[p]) begin
        if (!rd_in_rng[p]) begin
          rd_data_d[p] = '0;
        end else if (wr_commit && (bus.wr_addr == rd_addr[p])) begin
          // Write-first bypass: fresh data never came from storage, so no parity check.
          rd_data_d[p] = bus.wr_data;
        end else begin
          rd_data_d[p] = rd_word[p][DATA_W-1:0];
`ifdef SRC_REGFILE_PARITY_EN
          par_err_d[p] = ^rd_word[p];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_INIT;
      cnt_q        <= '0;
      rd_data_q[0] <= '0;
      rd_data_q[1] <= '0;
      rd_valid_q   <= '0;
      par_err_q    <= '0;
      wr_drop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_data_q[0] <= rd_data_d[0];
      rd_data_q[1] <= rd_data_d[1];
      rd_valid_q   <= rd_valid_d;
      par_err_q    <= par_err_d;
      wr_drop_q    <= wr_drop_d;
    end
  end

  // Storage has no reset; the clear sequencer owns it whenever the FSM is in INIT.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_commit) begin
`ifdef SRC_REGFILE_PARITY_EN
      mem_q[bus.wr_addr] <= {^bus.wr_data, bus.wr_data};
`else
      mem_q[bus.wr_addr] <= bus.wr_data;
`endif
    end
  end

  assign bus.rd_data_a  = rd_data_q[0];
  assign bus.rd_data_b  = rd_data_q[1];
  assign bus.rd_valid_a = rd_valid_q[0];
  assign bus.rd_valid_b = rd_valid_q[1];
  assign bus.par_err_a  = par_err_q[0];
  assign bus.par_err_b  = par_err_q[1];
  assign bus.wr_drop    = wr_drop_q;
  assign bus.busy       = !run;
  assign dbg_state_o    = run;

endmodule
